gl_commit_unit: RTL and testbench

Retirement controller that consumes the oldest one or two entries presented by the graduation list each cycle. It decides how many entries retire and returns that count to the graduation list as the read request. It serialises CSR instructions through a request/response handshake with the CSR file, gates store retirement on store-buffer readiness, and turns a head exception into a one-cycle commit flush. It sits between the graduation list and the CSR file / store buffer in the writeback stage.

---
 rtl/gl_commit_unit.sv | 148 ++++++++++++++
 tb/tb_gl_commit_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gl_commit_unit.sv
// gl_commit_unit: graduation-list retirement controller.
// Optional macro COMMIT_STATS_EN adds the retired_count_o counter.

package gl_commit_pkg;
   localparam int NUM_ENTRIES = 32;
   localparam int GL_IDX_W    = $clog2(NUM_ENTRIES);

   typedef logic [GL_IDX_W-1:0] gl_index_t;

   typedef enum logic [2:0] {
      INSTR_NONE   = 3'd0,
      INSTR_ALU    = 3'd1,
      INSTR_LOAD   = 3'd2,
      INSTR_STORE  = 3'd3,
      INSTR_AMO    = 3'd4,
      INSTR_BRANCH = 3'd5
   } instr_type_t;

   typedef struct packed {
      logic [31:0] pc;
      instr_type_t instr_type;
      logic        ex_valid;
   } gl_instruction_t;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception_t;
endpackage

module gl_commit_unit
   import gl_commit_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  gl_instruction_t [1:0] gl_instr_i,
   input  logic [1:0]            gl_is_csr_i,
   input  gl_index_t             gl_head_i,
   input  exception_t            gl_exception_i,
   output logic [1:0]            read_head_o,
   output logic                  flush_commit_o,
   output exception_t            exception_o,
   output gl_index_t             commit_gl_entry_o,
   output logic                  store_commit_o,
   input  logic                  store_ready_i,
   output logic                  csr_req_o,
   input  logic                  csr_resp_valid_i,
   input  logic                  csr_flush_i
`ifdef COMMIT_STATS_EN
   ,output logic [63:0]          retired_count_o
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      CSR_WAIT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   state_t     state_q, state_n;
   exception_t exc_q;
   logic       exc_latch;
   logic       s0_v, s1_v;
   logic       s0_st, s1_st;
   logic       s0_ret, s1_ret;

   assign s0_v  = (gl_instr_i[0] != '0);
   assign s1_v  = (gl_instr_i[1] != '0);
   assign s0_st = (gl_instr_i[0].instr_type == INSTR_STORE) ||
                  (gl_instr_i[0].instr_type == INSTR_AMO);
   assign s1_st = (gl_instr_i[1].instr_type == INSTR_STORE) ||
                  (gl_instr_i[1].instr_type == INSTR_AMO);

   assign commit_gl_entry_o = gl_head_i;
   assign flush_commit_o    = (state_q == FLUSH);
   assign exception_o       = exc_q;

   // state register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= RUN;
      else         state_q <= state_n;
   end

   // retire decision, handshakes and next state; outputs forced idle in reset
   always_comb begin
      state_n        = state_q;
      read_head_o    = 2'b00;
      store_commit_o = 1'b0;
      csr_req_o      = 1'b0;
      exc_latch      = 1'b0;
      s0_ret         = 1'b0;
      s1_ret         = 1'b0;
      if (rstn_i) begin
         unique case (state_q)
            RUN: begin
               if (s0_v) begin
                  unique case (1'b1)
                     gl_instr_i[0].ex_valid: begin
                        exc_latch = 1'b1;
                        state_n   = FLUSH;
                     end
                     gl_is_csr_i[0]: begin
                        csr_req_o = 1'b1;
                        state_n   = CSR_WAIT;
                     end
                     default: s0_ret = !s0_st || store_ready_i;
                  endcase
               end
               s1_ret = s0_ret && s1_v &&
                        !gl_instr_i[1].ex_valid && !gl_is_csr_i[1] &&
                        (!s1_st || (!s0_st && store_ready_i));
               read_head_o    = {s1_ret, s0_ret};
               store_commit_o = (s0_ret && s0_st) || (s1_ret && s1_st);
            end
            CSR_WAIT: begin
               csr_req_o = 1'b1;
               if (csr_resp_valid_i) begin
                  read_head_o = 2'b01;
                  state_n     = csr_flush_i ? FLUSH : RUN;
               end
            end
            FLUSH: state_n = RUN;
            default: state_n = RUN;
         endcase
      end
   end

   // exception captured when the head entry faults; held until the next one
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)        exc_q <= '0;
      else if (exc_latch) exc_q <= gl_exception_i;
   end

`ifdef COMMIT_STATS_EN
   logic [63:0] count_q;

   // running total of retired instructions, wraps naturally
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) count_q <= '0;
      else         count_q <= count_q + {63'd0, read_head_o[1]}
                                      + {63'd0, read_head_o[0]};
   end

   assign retired_count_o = count_q;
`endif

endmodule

// File: tb/tb_gl_commit_unit.sv
// tb_gl_commit_unit: directed self-checking bench for gl_commit_unit.
// Checks are immediate assertions on hand-computed expectations.

module tb_gl_commit_unit;
   import gl_commit_pkg::*;

   logic                  clk;
   logic                  rstn;
   gl_instruction_t [1:0] gl_instr;
   logic [1:0]            gl_is_csr;
   gl_index_t             gl_head;
   exception_t            gl_exc;
   logic [1:0]            read_head;
   logic                  flush_commit;
   exception_t            exc_out;
   gl_index_t             commit_entry;
   logic                  store_commit;
   logic                  store_ready;
   logic                  csr_req;
   logic                  csr_resp_valid;
   logic                  csr_flush;
`ifdef COMMIT_STATS_EN
   logic [63:0]           retired_count;
`endif

   int errors = 0;
   int checks = 0;
   int req_cycles;

   gl_commit_unit dut (
      .clk_i             (clk),
      .rstn_i            (rstn),
      .gl_instr_i        (gl_instr),
      .gl_is_csr_i       (gl_is_csr),
      .gl_head_i         (gl_head),
      .gl_exception_i    (gl_exc),
      .read_head_o       (read_head),
      .flush_commit_o    (flush_commit),
      .exception_o       (exc_out),
      .commit_gl_entry_o (commit_entry),
      .store_commit_o    (store_commit),
      .store_ready_i     (store_ready),
      .csr_req_o         (csr_req),
      .csr_resp_valid_i  (csr_resp_valid),
      .csr_flush_i       (csr_flush)
`ifdef COMMIT_STATS_EN
      ,.retired_count_o  (retired_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic gl_instruction_t mk(input instr_type_t t,
                                          input logic ex);
      gl_instruction_t e;
      e.pc         = 32'h1000;
      e.instr_type = t;
      e.ex_valid   = ex;
      return e;
   endfunction

   task automatic idle_inputs();
      gl_instr       = '0;
      gl_is_csr      = 2'b00;
      gl_exc         = '0;
      store_ready    = 1'b0;
      csr_resp_valid = 1'b0;
      csr_flush      = 1'b0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      rstn    = 1'b0;
      gl_head = '0;
      idle_inputs();
      #3;
      check("rst_read_head", read_head, 2'b00);
      check("rst_flush", flush_commit, 1'b0);
      check("rst_exception", exc_out, '0);
      check("rst_store", store_commit, 1'b0);
      check("rst_csr_req", csr_req, 1'b0);
`ifdef COMMIT_STATS_EN
      check("rst_count", retired_count, 64'd0);
`endif
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;

      // dual retire
      nxt();
      gl_instr[0] = mk(INSTR_ALU, 1'b0);
      gl_instr[1] = mk(INSTR_ALU, 1'b0);
      gl_head     = 5'd5;
      mid();
      check("dual_read_head", read_head, 2'b11);
      check("dual_entry", commit_entry, 5'd5);
      check("dual_store", store_commit, 1'b0);

      // store gating
      for (int i = 0; i < 3; i++) begin
         nxt();
         idle_inputs();
         gl_instr[0] = mk(INSTR_STORE, 1'b0);
         mid();
         check("st_wait_read_head", read_head, 2'b00);
         check("st_wait_store", store_commit, 1'b0);
      end
      nxt();
      store_ready = 1'b1;
      mid();
      check("st_go_read_head", read_head, 2'b01);
      check("st_go_store", store_commit, 1'b1);

      // two stores never retire together
      nxt();
      gl_instr[1] = mk(INSTR_STORE, 1'b0);
      mid();
      check("st2_read_head", read_head, 2'b01);
      check("st2_store", store_commit, 1'b1);

      // store/AMO in slot 1 behind an ALU
      nxt();
      gl_instr[0] = mk(INSTR_ALU, 1'b0);
      gl_instr[1] = mk(INSTR_AMO, 1'b0);
      mid();
      check("alu_amo_read_head", read_head, 2'b11);
      check("alu_amo_store", store_commit, 1'b1);
      nxt();
      store_ready = 1'b0;
      mid();
      check("alu_amo_nrdy_read_head", read_head, 2'b01);
      check("alu_amo_nrdy_store", store_commit, 1'b0);

      // slot 1 exception / CSR deferred
      nxt();
      gl_instr[1] = mk(INSTR_LOAD, 1'b1);
      mid();
      check("s1_exc_read_head", read_head, 2'b01);
      nxt();
      gl_instr[1] = mk(INSTR_ALU, 1'b0);
      gl_is_csr   = 2'b10;
      mid();
      check("s1_csr_read_head", read_head, 2'b01);
      check("s1_csr_req", csr_req, 1'b0);

      // exception at head
      nxt();
      idle_inputs();
      gl_instr[0]  = mk(INSTR_LOAD, 1'b1);
      gl_exc.cause = 64'd2;
      gl_exc.valid = 1'b1;
      mid();
      check("exc_read_head", read_head, 2'b00);
      check("exc_flush_early", flush_commit, 1'b0);
      nxt();
      gl_instr[0]  = mk(INSTR_ALU, 1'b0);
      gl_exc.cause = 64'd7;
      mid();
      check("exc_flush", flush_commit, 1'b1);
      check("exc_flush_read_head", read_head, 2'b00);
      check("exc_cause", exc_out.cause, 64'd2);
      nxt();
      mid();
      check("exc_after_flush", flush_commit, 1'b0);
      check("exc_after_read_head", read_head, 2'b01);
      check("exc_cause_hold", exc_out.cause, 64'd2);

      // CSR with flush; early response ignored
      req_cycles = 0;
      nxt();
      idle_inputs();
      gl_instr[0]    = mk(INSTR_ALU, 1'b0);
      gl_is_csr      = 2'b01;
      csr_resp_valid = 1'b1;
      mid();
      check("csr_first_req", csr_req, 1'b1);
      check("csr_first_read_head", read_head, 2'b00);
      if (csr_req) req_cycles++;
      for (int i = 0; i < 3; i++) begin
         nxt();
         csr_resp_valid = 1'b0;
         mid();
         check("csr_wait_read_head", read_head, 2'b00);
         if (csr_req) req_cycles++;
      end
      nxt();
      csr_resp_valid = 1'b1;
      csr_flush      = 1'b1;
      mid();
      check("csr_resp_read_head", read_head, 2'b01);
      if (csr_req) req_cycles++;
      check("csr_req_cycles", req_cycles, 5);
      nxt();
      idle_inputs();
      mid();
      check("csr_flush", flush_commit, 1'b1);
      check("csr_flush_req", csr_req, 1'b0);
      nxt();
      mid();
      check("csr_flush_done", flush_commit, 1'b0);

      // reset while in CSR_WAIT
      nxt();
      gl_instr[0] = mk(INSTR_ALU, 1'b0);
      gl_is_csr   = 2'b01;
      mid();
      check("rcsr_req", csr_req, 1'b1);
      nxt();
      #2;
      rstn = 1'b0;
      #1;
      check("rcsr_req_rst", csr_req, 1'b0);
      check("rcsr_read_head_rst", read_head, 2'b00);
      check("rcsr_flush_rst", flush_commit, 1'b0);
      check("rcsr_exc_rst", exc_out, '0);
      mid();
      nxt();
      rstn = 1'b1;
      mid();
      check("rcsr_rereq", csr_req, 1'b1);
      check("rcsr_rereq_read_head", read_head, 2'b00);
      nxt();
      csr_resp_valid = 1'b1;
      mid();
      check("rcsr_resp_read_head", read_head, 2'b01);
      nxt();
      idle_inputs();
      mid();
      check("rcsr_done_req", csr_req, 1'b0);
      check("rcsr_done_flush", flush_commit, 1'b0);

`ifdef COMMIT_STATS_EN
      // retired count: 11, 01, CSR
      nxt();
      rstn = 1'b0;
      #2;
      check("stats_rst", retired_count, 64'd0);
      mid();
      rstn = 1'b1;
      nxt();
      gl_instr[0] = mk(INSTR_ALU, 1'b0);
      gl_instr[1] = mk(INSTR_ALU, 1'b0);
      nxt();
      gl_instr[1] = '0;
      nxt();
      gl_is_csr = 2'b01;
      nxt();
      csr_resp_valid = 1'b1;
      nxt();
      idle_inputs();
      mid();
      check("stats_count", retired_count, 64'd4);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
